// File: rtl/pulse_timer_pkg.sv
// Shared types and constants for the pulse timer.
// Holds the FSM state encoding and the mode encoding sampled with start.
package pulse_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/pulse_timer_if.sv
// Control/status bundle of the pulse timer. The controller drives the master side.
// The timer takes the slave side. Settings are sampled only in a start cycle.
interface pulse_timer_if #(
  parameter int WIDTH = 32
);

  logic             en;
  logic             start;
  logic             stop;
  logic             mode;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_len;
  logic             out;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] count;

  modport master (
    output en, start, stop, mode, period, high_len,
    input  out, busy, done, count
  );

  modport slave (
    input  en, start, stop, mode, period, high_len,
    output out, busy, done, count
  );

endinterface

// File: rtl/pulse_timer_load_down_counter.sv
// Loadable down-counter. A load wins over counting and takes effect on the next edge.
// With en high it decrements and then holds at zero. With en low it holds its value.
module load_down_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] value,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (en && (value != '0)) begin
      value <= value - WIDTH'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/pulse_timer.sv
// Programmable periodic/one-shot pulse generator. The counter loads P-1 on the start edge.
// en low freezes the counter, the state and out. A reload waits for the next period wrap.
module pulse_timer
  import pulse_timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  pulse_timer_if.slave   bus
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] act_p, act_h;
  logic             act_mode;
  logic [WIDTH-1:0] pend_p, pend_h;
  logic             pend_vld;
  logic             done_q, done_nxt;

  logic             cnt_en, cnt_ld, cnt_zero;
  logic [WIDTH-1:0] cnt_ld_val, cnt_val;
  logic             latch_act, latch_pend, promote, clr_pend;

  load_down_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (cnt_en),
    .load     (cnt_ld),
    .load_val (cnt_ld_val),
    .value    (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nxt  = state;
    done_nxt   = 1'b0;
    cnt_en     = 1'b0;
    cnt_ld     = 1'b0;
    cnt_ld_val = '0;
    latch_act  = 1'b0;
    latch_pend = 1'b0;
    promote    = 1'b0;
    clr_pend   = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.start && !bus.stop && (bus.period != '0)) begin
          latch_act  = 1'b1;
          cnt_ld     = 1'b1;
          cnt_ld_val = bus.period - WIDTH'(1);
          state_nxt  = RUN;
        end
      end
      RUN: begin
        if (bus.stop) begin
          // Abort: counter cleared, pending reload dropped, done stays low.
          state_nxt  = IDLE;
          cnt_ld     = 1'b1;
          cnt_ld_val = '0;
          clr_pend   = 1'b1;
        end else begin
          if (bus.start && (act_mode == MODE_PERIODIC) && (bus.period != '0)) begin
            latch_pend = 1'b1;
          end
          if (bus.en) begin
            if (!cnt_zero) begin
              cnt_en = 1'b1;
            end else if (act_mode == MODE_PERIODIC) begin
              cnt_ld = 1'b1;
              if (pend_vld) begin
                promote    = 1'b1;
                cnt_ld_val = pend_p - WIDTH'(1);
              end else begin
                cnt_ld_val = act_p - WIDTH'(1);
              end
            end else begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      done_q   <= 1'b0;
      act_p    <= '0;
      act_h    <= '0;
      act_mode <= MODE_PERIODIC;
      pend_p   <= '0;
      pend_h   <= '0;
      pend_vld <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= done_nxt;

      if (latch_act) begin
        act_p    <= bus.period;
        act_h    <= bus.high_len;
        act_mode <= bus.mode;
      end else if (promote) begin
        act_p <= pend_p;
        act_h <= pend_h;
      end

      // A start landing on the wrap edge queues behind the value being promoted.
      if (latch_pend) begin
        pend_p   <= bus.period;
        pend_h   <= bus.high_len;
        pend_vld <= 1'b1;
      end else if (promote || clr_pend) begin
        pend_vld <= 1'b0;
      end
    end
  end

  // Built from registers only, so the output cannot glitch on input changes.
  assign bus.out   = (state == RUN) && (cnt_val < act_h);
  assign bus.busy  = (state == RUN);
  assign bus.done  = done_q;
  assign bus.count = cnt_val;

endmodule
